pipelined_sparse_ling_adder: RTL and testbench
==============================================

// Module: pipelined_sparse_ling_adder
// PURPOSE
//  Parametrised, pipelined sparse-2 Ling parallel-prefix adder with two modes:
//  - plain 2^N addition with carry-in/carry-out;
//  - modulo 2^N-1 addition using a cyclic prefix and end-around carry.
//  Three register stages and a valid/ready handshake, so it drops into streaming
//  datapaths (RNS/checksum units) in place of the fixed 8-bit combinational adders.
// PARAMETERS
//  N          8  operand width; even, 4..64 (sparse-2 pairing needs even N)
//  NORM_ZERO  1  mod mode: 1 = an all-ones result (negative zero) is output as 0
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous active-low reset
//  in_valid   in   1  operand beat valid
//  in_ready   out  1  block can accept a beat this cycle
//  a          in   N  operand A
//  b          in   N  operand B
//  cin        in   1  carry-in; ignored when mode=1
//  mode       in   1  0 = mod 2^N with carry, 1 = mod 2^N-1 (end-around)
//  out_valid  out  1  result beat valid
//  out_ready  in   1  downstream accepts the result
//  sum        out  N  result
//  cout       out  1  carry-out (mode 0); 0 in mode 1
// BEHAVIOUR
//  - Reset: all stage valid bits 0; out_valid=0; sum=0; cout=0; in_ready=1 once
//    rst_n deasserts. Asserting rst_n mid-operation discards all beats in flight.
//  - Stage S1 registers per-bit g=a&b, p=a|b, x=a^b, plus mode and cin.
//  - Stage S2 computes pair G/P (sparse-2, odd bit positions), then a log2(N/2)-level
//    prefix: linear in mode 0, cyclic (indices wrap mod N/2) in mode 1. Registers
//    group carries at each even bit boundary.
//  - Stage S3 forms sum pairs from x, g, p and the incoming group carry:
//    - carry into bit 0 is cin (mode 0) or the full-width cyclic carry (mode 1);
//    - cout = carry out of bit N-1 (mode 0 only).
//    Then applies NORM_ZERO and registers sum/cout.
//  - Latency: exactly 3 cycles from an accepted input beat to out_valid with no stall.
//  - Handshake: a beat is accepted when in_valid&in_ready; a result is consumed when
//    out_valid&out_ready.
//    - Each stage advances when its successor is empty or advancing.
//    - in_ready = ~S1.valid | S1 advancing (full throughput, no bubbles under
//      continuous out_ready=1).
//  - Stall: out_valid=1 & out_ready=0 freezes all full stages; sum/cout stay stable
//    until consumed. With all 3 stages full, in_ready=0.
//  - Simultaneous accept and consume on a full pipe: both happen; occupancy unchanged.
//  - mode and cin travel with their beat; mixed-mode back-to-back beats are legal.
//  - Width rules: no internal truncation beyond N bits. In mode 1, operands are
//    residues 0..2^N-1 (all-ones is accepted as zero).
// STRUCTURE
//  - Shared package: stage-count constant (3), the mode encoding, and the
//    N-even/N-range check function.
//  - One sub-module: sparse_prefix_net (N/2 pair inputs, cyclic enable input,
//    combinational G outputs), instantiated in S2.
//  - Pipeline control stays in this module.
// TESTING
//  - N=8, mode0: a=200 b=100 cin=0 -> sum=0x2C cout=1, out_valid 3 cycles later.
//  - N=8, mode0: a=0xFF b=0x00 cin=1 -> sum=0x00 cout=1.
//  - N=8, mode1: a=200 b=100 -> sum=45 (300 mod 255), cout=0.
//  - N=8, mode1: a=128 b=127 -> sum=0x00 (NORM_ZERO=1) / 0xFF (NORM_ZERO=0).
//  - 100 random back-to-back beats, random out_ready (~50%): results match a
//    reference model in order; no loss/duplication; sum stable while stalled;
//    in_ready=0 when all 3 stages are full.
//  - rst_n pulsed low with 2 beats in flight -> out_valid=0, sum=0 immediately;
//    first beat after reset emerges 3 cycles after acceptance.

Source files
------------

// File: rtl/pipelined_sparse_ling_adder_pkg.sv
// Shared definitions for the pipelined sparse-2 Ling adder.
//   PIPE_STAGES : number of register stages between operand accept and result
//   add_mode_e  : operation select (binary 2^N add or end-around 2^N-1 add)
//   width_ok()  : legality check for the operand width parameter
package pipelined_sparse_ling_adder_pkg;

  localparam int unsigned PIPE_STAGES = 32'd3;

  typedef enum logic {
    MODE_BIN = 1'b0,   // modulo 2^N with carry-in / carry-out
    MODE_MOD = 1'b1    // modulo 2^N-1, end-around carry
  } add_mode_e;

  // Operands are paired two bits at a time, so the width must be even.
  function automatic logic width_ok(input int unsigned n);
    return (n >= 32'd4) && (n <= 32'd64) && ((n % 32'd2) == 32'd0);
  endfunction

endpackage

// File: rtl/pipelined_sparse_ling_adder_sparse_prefix_net.sv
// Kogge-Stone style prefix network over Ling pair terms.
//   i_h      : per-pair Ling pseudo-generate
//   i_t      : per-pair Ling transmit (propagate shifted down one bit)
//   i_cyclic : 1 = indices wrap modulo M (end-around), 0 = linear prefix
//   o_h      : per-pair group pseudo-carry H (pair j down to pair 0, or all M
//              pairs ending at j when cyclic)
// Purely combinational.
module sparse_prefix_net #(
  parameter int unsigned M = 4
) (
  input  logic [M-1:0] i_h,
  input  logic [M-1:0] i_t,
  input  logic         i_cyclic,
  output logic [M-1:0] o_h
);

  localparam int unsigned L = (M > 32'd1) ? $clog2(M) : 32'd1;

  // Level k holds spans of 2^k pairs; transmit of the last level is never needed.
  wire [L:0][M-1:0]   w_h;
  wire [L-1:0][M-1:0] w_t;

  assign w_h[0] = i_h;
  assign w_t[0] = i_t;

  for (genvar lv = 0; lv < L; lv++) begin : g_lvl
    localparam int D = 1 << lv;
    for (genvar j = 0; j < M; j++) begin : g_node
      if (j >= D) begin : g_lin
        assign w_h[lv+1][j] = w_h[lv][j] | (w_t[lv][j] & w_h[lv][j-D]);
        if (lv + 1 < L) begin : g_t
          assign w_t[lv+1][j] = w_t[lv][j] & w_t[lv][j-D];
        end
      end else begin : g_wrap
        // Only the cyclic prefix has a predecessor here (wrapping to the top).
        // Spans longer than M are harmless: the extra terms are absorbed.
        assign w_h[lv+1][j] = w_h[lv][j] | (i_cyclic & w_t[lv][j] & w_h[lv][j+M-D]);
        if (lv + 1 < L) begin : g_t
          assign w_t[lv+1][j] = w_t[lv][j] & (~i_cyclic | w_t[lv][j+M-D]);
        end
      end
    end
  end

  assign o_h = w_h[L];

endmodule

// File: rtl/pipelined_sparse_ling_adder.sv
// Three-stage pipelined sparse-2 Ling adder with valid/ready handshake.
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_in_valid / o_in_ready   : operand beat handshake
//   i_a, i_b, i_cin, i_mode   : operands, carry-in (mode 0 only), mode select
//   o_out_valid / i_out_ready : result beat handshake
//   o_sum, o_cout             : result and carry-out (0 in mode 1)
// S1 registers bitwise g/p/x, S2 registers the carry into every even bit,
// S3 registers the final sum.
module pipelined_sparse_ling_adder
  import pipelined_sparse_ling_adder_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter bit          NORM_ZERO = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  input  logic         i_mode,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  localparam int unsigned M = N / 2;

  if (!width_ok(N)) begin : g_bad_width
    $error("pipelined_sparse_ling_adder: N must be even and within 4..64");
  end

  // Stage registers
  logic         r_s1_valid;
  logic [N-1:0] r_s1_g, r_s1_p, r_s1_x;
  logic         r_s1_cin;
  add_mode_e    r_s1_mode;

  logic         r_s2_valid;
  logic [M-1:0] r_s2_c;      // carry into bit 2j
  logic [M-1:0] r_s2_ge;     // g at even bits
  logic [M-1:0] r_s2_pe;     // p at even bits
  logic         r_s2_gtop, r_s2_ptop;
  logic [N-1:0] r_s2_x;
  add_mode_e    r_s2_mode;

  logic         r_s3_valid;
  logic [N-1:0] r_s3_sum;
  logic         r_s3_cout;

  // Handshake: a stage may load when it is empty or its content moves on.
  wire w_s3_free = ~r_s3_valid | i_out_ready;
  wire w_s2_free = ~r_s2_valid | w_s3_free;
  wire w_s1_free = ~r_s1_valid | w_s2_free;

  assign o_in_ready  = w_s1_free;
  assign o_out_valid = r_s3_valid;
  assign o_sum       = r_s3_sum;
  assign o_cout      = r_s3_cout;

  // ---------------- S2 combinational: Ling pair terms and prefix ----------
  wire          w_s1_mod = (r_s1_mode == MODE_MOD);
  wire [M-1:0]  w_pair_h, w_pair_t, w_pref_h, w_grp_c, w_s1_ge, w_s1_pe;

  for (genvar j = 0; j < M; j++) begin : g_pair
    assign w_s1_ge[j] = r_s1_g[2*j];
    assign w_s1_pe[j] = r_s1_p[2*j];
    if (j == 0) begin : g_lsb
      // Mode 0 folds cin into the lowest pseudo-generate; mode 1 borrows the
      // transmit bit from the top of the word instead (end-around).
      assign w_pair_h[0] = r_s1_g[1] | r_s1_g[0] | (~w_s1_mod & r_s1_p[0] & r_s1_cin);
      assign w_pair_t[0] = r_s1_p[0] & (~w_s1_mod | r_s1_p[N-1]);
      assign w_grp_c[0]  = w_s1_mod ? (r_s1_p[N-1] & w_pref_h[M-1]) : r_s1_cin;
    end else begin : g_upper
      // Ling: H = g1|g0, and the real carry is recovered as p(prev bit) & H.
      assign w_pair_h[j] = r_s1_g[2*j+1] | r_s1_g[2*j];
      assign w_pair_t[j] = r_s1_p[2*j] & r_s1_p[2*j-1];
      assign w_grp_c[j]  = r_s1_p[2*j-1] & w_pref_h[j-1];
    end
  end

  sparse_prefix_net #(.M(M)) u_prefix (
    .i_h      (w_pair_h),
    .i_t      (w_pair_t),
    .i_cyclic (w_s1_mod),
    .o_h      (w_pref_h)
  );

  // ---------------- S3 combinational: pair sums ---------------------------
  wire [M-1:0] w_s3_c_hi;    // carry into bit 2j+1
  wire [N-1:0] w_s3_sum;

  for (genvar j = 0; j < M; j++) begin : g_sum
    assign w_s3_c_hi[j]      = r_s2_ge[j] | (r_s2_pe[j] & r_s2_c[j]);
    assign w_s3_sum[2*j]     = r_s2_x[2*j] ^ r_s2_c[j];
    assign w_s3_sum[2*j+1]   = r_s2_x[2*j+1] ^ w_s3_c_hi[j];
  end

  wire w_s3_co = r_s2_gtop | (r_s2_ptop & w_s3_c_hi[M-1]);

  logic [N-1:0] w_s3_res;
  logic         w_s3_cout;

  // Final result select: negative-zero normalisation and mode-0-only carry-out.
  always_comb begin
    w_s3_res  = w_s3_sum;
    w_s3_cout = 1'b0;
    if ((r_s2_mode == MODE_MOD) && NORM_ZERO && (&w_s3_sum)) begin
      w_s3_res = '0;
    end else begin
      w_s3_res = w_s3_sum;
    end
    if (r_s2_mode == MODE_BIN) begin
      w_s3_cout = w_s3_co;
    end else begin
      w_s3_cout = 1'b0;
    end
  end

  // S1: capture bitwise generate / propagate / half-sum with mode and cin.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_g     <= '0;
      r_s1_p     <= '0;
      r_s1_x     <= '0;
      r_s1_cin   <= 1'b0;
      r_s1_mode  <= MODE_BIN;
    end else if (w_s1_free) begin
      r_s1_valid <= i_in_valid;
      if (i_in_valid) begin
        r_s1_g    <= i_a & i_b;
        r_s1_p    <= i_a | i_b;
        r_s1_x    <= i_a ^ i_b;
        r_s1_cin  <= i_cin;
        r_s1_mode <= add_mode_e'(i_mode);
      end
    end
  end

  // S2: capture carries at every even bit boundary plus what S3 still needs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_c     <= '0;
      r_s2_ge    <= '0;
      r_s2_pe    <= '0;
      r_s2_gtop  <= 1'b0;
      r_s2_ptop  <= 1'b0;
      r_s2_x     <= '0;
      r_s2_mode  <= MODE_BIN;
    end else if (w_s2_free) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_c    <= w_grp_c;
        r_s2_ge   <= w_s1_ge;
        r_s2_pe   <= w_s1_pe;
        r_s2_gtop <= r_s1_g[N-1];
        r_s2_ptop <= r_s1_p[N-1];
        r_s2_x    <= r_s1_x;
        r_s2_mode <= r_s1_mode;
      end
    end
  end

  // S3: result register; holds steady while downstream stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s3_valid <= 1'b0;
      r_s3_sum   <= '0;
      r_s3_cout  <= 1'b0;
    end else if (w_s3_free) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_sum  <= w_s3_res;
        r_s3_cout <= w_s3_cout;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_sparse_ling_adder.sv
module tb_pipelined_sparse_ling_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = 8'd0, b = 8'd0;
  logic       cin = 1'b0, mode = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, cout;
  logic [7:0] sum;
  logic       in_ready2, out_valid2, cout2;
  logic [7:0] sum2;

  int n_chk = 0;
  int n_err = 0;
  int n_full = 0;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic [7:0] s2;
  } exp_t;
  exp_t q[$];

  logic       have_stall = 1'b0;
  logic [7:0] prev_sum = 8'd0;
  logic       prev_cout = 1'b0;

  always #5 clk = ~clk;

  pipelined_sparse_ling_adder #(.N(8), .NORM_ZERO(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a(a), .i_b(b), .i_cin(cin), .i_mode(mode),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_sum(sum), .o_cout(cout)
  );

  pipelined_sparse_ling_adder #(.N(8), .NORM_ZERO(1'b0)) dut_nz0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready2),
    .i_a(a), .i_b(b), .i_cin(cin), .i_mode(mode),
    .o_out_valid(out_valid2), .i_out_ready(out_ready), .o_sum(sum2), .o_cout(cout2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {cout, sum}.
  function automatic logic [8:0] model(input int unsigned ma, input int unsigned mb,
                                       input logic mc, input logic mm, input logic nz);
    int unsigned t;
    int unsigned r;
    if (!mm) begin
      t = ma + mb + (mc ? 1 : 0);
      return {t >= 256 ? 1'b1 : 1'b0, 8'(t % 256)};
    end
    t = ma + mb;
    r = t % 255;
    if (!nz && r == 0 && t != 0) r = 255;   // un-normalised negative zero
    return {1'b0, 8'(r)};
  endfunction

  // Scoreboard: push on accept, pop and compare on consume, every cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [8:0] m1, m2;
    if (!rst_n) begin
      q.delete();
      have_stall = 1'b0;
    end else begin
      chk("in_ready", in_ready, (q.size() < 3) || out_ready);
      chk("nz0_valid_track", out_valid2, out_valid);
      if (q.size() == 3) n_full++;
      if (q.size() == 0) chk("idle_out_valid", out_valid, 1'b0);
      if (have_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_sum", sum, prev_sum);
        chk("stall_cout", cout, prev_cout);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          chk("sum", sum, e.s);
          chk("cout", cout, e.c);
          chk("sum_nz0", sum2, e.s2);
        end
      end
      if (in_valid && in_ready) begin
        m1 = model(a, b, cin, mode, 1'b1);
        m2 = model(a, b, cin, mode, 1'b0);
        e.s = m1[7:0]; e.c = m1[8]; e.s2 = m2[7:0];
        q.push_back(e);
      end
      have_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_cout  = cout;
    end
  end

  // One beat into an empty pipe: checks latency and literal expectations.
  task automatic send_one(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                          input logic tm, input logic [7:0] es, input logic ec,
                          input logic [7:0] es2, input string nm);
    int lat;
    @(posedge clk); #1;
    a = ta; b = tb_; cin = tc; mode = tm; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    chk({nm, "_latency"}, lat, 3);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec);
    chk({nm, "_sum_nz0"}, sum2, es2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin
    logic acc;
    int   tries;
    int   t;

    // Pin the reference model to hand-computed values.
    chk("model_200_100", model(200, 100, 1'b0, 1'b0, 1'b1), 9'h12C);
    chk("model_ff_cin", model(255, 0, 1'b1, 1'b0, 1'b1), 9'h100);
    chk("model_mod_300", model(200, 100, 1'b0, 1'b1, 1'b1), 9'h02D);
    chk("model_negzero", model(128, 127, 1'b0, 1'b1, 1'b0), 9'h0FF);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // Directed vectors.
    send_one(8'd200, 8'd100, 1'b0, 1'b0, 8'h2C, 1'b1, 8'h2C, "m0_200_100");
    send_one(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, "m0_ff_cin");
    send_one(8'd200, 8'd100, 1'b0, 1'b1, 8'd45, 1'b0, 8'd45, "m1_200_100");
    send_one(8'd128, 8'd127, 1'b0, 1'b1, 8'h00, 1'b0, 8'hFF, "m1_negzero");
    send_one(8'd1, 8'd2, 1'b1, 1'b1, 8'd3, 1'b0, 8'd3, "m1_cin_ignored");
    send_one(8'hFF, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, 8'hFF, "m1_ff_ff");
    send_one(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 8'hFF, "m0_ff_ff_cin");

    // Random back-to-back beats with ~50% out_ready.
    @(posedge clk); #1;
    for (int k = 0; k < 100; k++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      mode = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      tries = 0;
      do begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        tries++;
      end while (!acc && tries < 200);
      if (!acc) chk("accept_timeout", tries, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", q.size(), 0);
    chk("full_pipe_seen", n_full > 0, 1'b1);

    // Reset with beats in flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    a = 8'd10; b = 8'd20; cin = 1'b0; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'd30; b = 8'd40;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    chk("pre_reset_valid", out_valid, 1'b1);
    chk("pre_reset_sum", sum, 8'd30);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_sum", sum, 8'h00);
    chk("async_rst_cout", cout, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_ghost", out_valid, 1'b0);
    end
    send_one(8'd200, 8'd100, 1'b0, 1'b1, 8'd45, 1'b0, 8'd45, "after_reset");

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
